// File: rtl/clock_display_mux.sv
// Multiplexed 4-digit common-anode 7-segment driver for the RTC.
// Shows a per-frame snapshot of the BCD digits, blanks a leading hour zero and
// inserts one dead cycle per slot to avoid ghosting. The colon blinks on slot 2.
module clock_display_mux #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 250,
    parameter int unsigned BLANK_LEAD   = 1
) (
    input  logic       div_clk,
    input  logic       rst_i,
    input  logic [3:0] hr1_i,
    input  logic [3:0] hr2_i,
    input  logic [3:0] min1_i,
    input  logic [3:0] min2_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int unsigned PreW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(REFRESH_DIV - 1);
    localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);

    logic [PreW-1:0]  pre_q, pre_d;
    logic [1:0]       scan_q, scan_d;
    logic [FrmW-1:0]  frame_q, frame_d;
    logic             phase_q, phase_d;
    // Indexed by slot: 0=min2, 1=min1, 2=hr2, 3=hr1.
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic             tick;
    logic             frame_end;

    // BCD to active-low segments (bit 6 = g ... bit 0 = a); non-BCD shows a dash.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick      = (pre_q == PreLast);
    assign frame_end = tick && (scan_q == 2'd3);

    // Next-state for prescaler, scan index, snapshot and blink phase.
    always_comb begin
        pre_d    = pre_q + 1'b1;
        scan_d   = scan_q;
        frame_d  = frame_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;
        if (tick) begin
            pre_d  = '0;
            scan_d = scan_q + 2'd1;
        end
        if (frame_end) begin
            // Whole-frame snapshot keeps the four digits coherent.
            shadow_d = {hr1_i, hr2_i, min1_i, min2_i};
            if (frame_q == FrmLast) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Display decode from the current (pre-edge) state; registered below.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (pre_q != '0) begin
            an_d  = ~(4'b0001 << scan_q);
            seg_d = encode(shadow_q[scan_q]);
            if ((scan_q == 2'd3) && (BLANK_LEAD != 0) && (shadow_q[3] == 4'd0)) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
            end
            if ((scan_q == 2'd2) && phase_q) begin
                dp_d = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge div_clk) begin
        if (rst_i) begin
            pre_q    <= '0;
            scan_q   <= 2'd0;
            frame_q  <= '0;
            phase_q  <= 1'b0;
            shadow_q <= '0;
            an_o     <= 4'b1111;
            seg_o    <= 7'b1111111;
            dp_o     <= 1'b1;
        end else begin
            pre_q    <= pre_d;
            scan_q   <= scan_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            an_o     <= an_d;
            seg_o    <= seg_d;
            dp_o     <= dp_d;
        end
    end

endmodule

// File: tb/tb_clock_display_mux.sv
// Directed bench for clock_display_mux with REFRESH_DIV=4, BLINK_FRAMES=2.
// Two instances share the inputs: one blanks a leading hour zero, one does not.
module tb_clock_display_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hr1, hr2, min1, min2;
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;   // edges since reset release

    clock_display_mux #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .BLANK_LEAD(1)) dut (
        .div_clk(clk), .rst_i(rst), .hr1_i(hr1), .hr2_i(hr2), .min1_i(min1),
        .min2_i(min2), .an_o(an_a), .seg_o(seg_a), .dp_o(dp_a)
    );

    clock_display_mux #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .BLANK_LEAD(0)) dut_nb (
        .div_clk(clk), .rst_i(rst), .hr1_i(hr1), .hr2_i(hr2), .min1_i(min1),
        .min2_i(min2), .an_o(an_b), .seg_o(seg_b), .dp_o(dp_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      hr1, hr2, min1, min2;
        logic [3:0][6:0] seg;   // expected encoding per slot 0..3
        logic            blank; // slot 3 blanked on the BLANK_LEAD=1 instance
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [3:0] h1, h2, m1, m2,
                                input logic [6:0] s0, s1, s2, s3, input logic bl);
        vec_t v;
        v.hr1 = h1; v.hr2 = h2; v.min1 = m1; v.min2 = m2;
        v.seg = {s3, s2, s1, s0};
        v.blank = bl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic drive(input vec_t v);
        hr1 = v.hr1; hr2 = v.hr2; min1 = v.min1; min2 = v.min2;
    endtask

    task automatic to_boundary();
        step();
        while (n % 16 != 0) step();
    endtask

    task automatic chk_off(input string name);
        chk({name, "_an"}, 32'(an_a), 32'hF);
        chk({name, "_seg"}, 32'(seg_a), 32'h7F);
        chk({name, "_dp"}, 32'(dp_a), 32'h1);
        chk({name, "_an_nb"}, 32'(an_b), 32'hF);
    endtask

    // Checks frame cycles k0..k1-1; assumes n == 16*frame + k0 on entry.
    task automatic run_frame(input vec_t v, input int k0, input int k1);
        logic [3:0] oh, ea, eb;
        logic [6:0] esa, esb;
        logic       edp;
        int         slot, pos, ph;
        for (int k = k0; k < k1; k++) begin
            step();
            slot = k / 4;
            pos  = k % 4;
            ph   = ((n - 1) / 16 / 2) % 2;
            oh   = 4'b0001 << slot;
            if (pos == 0) begin
                ea = 4'hF; eb = 4'hF; esa = 7'h7F; esb = 7'h7F; edp = 1'b1;
            end else begin
                ea  = ~oh; eb = ~oh;
                esa = v.seg[slot]; esb = v.seg[slot];
                edp = (slot == 2 && ph == 1) ? 1'b0 : 1'b1;
                if (slot == 3 && v.blank) begin
                    ea = 4'hF; esa = 7'h7F;
                end
            end
            chk("an", 32'(an_a), 32'(ea));
            chk("seg", 32'(seg_a), 32'(esa));
            chk("dp", 32'(dp_a), 32'(edp));
            chk("an_nb", 32'(an_b), 32'(eb));
            chk("seg_nb", 32'(seg_b), 32'(esb));
            chk("dp_nb", 32'(dp_b), 32'(edp));
        end
    endtask

    initial begin
        int lows, bad, rr;
        vec_t v;
        vecs[0] = mk(0, 0, 0, 0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 1);
        vecs[1] = mk(1, 2, 3, 4, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 0);
        vecs[2] = mk(0, 9, 5, 8, 7'b0000000, 7'b0010010, 7'b0010000, 7'b1000000, 1);
        vecs[3] = mk(1, 0, 12, 6, 7'b0000010, 7'b0111111, 7'b1000000, 7'b1111001, 0);
        vecs[4] = mk(15, 7, 10, 13, 7'b0111111, 7'b0111111, 7'b1111000, 7'b0111111, 0);
        vecs[5] = mk(2, 3, 4, 1, 7'b1111001, 7'b0011001, 7'b0110000, 7'b0100100, 0);
        vecs[6] = mk(1, 8, 9, 7, 7'b1111000, 7'b0010000, 7'b0000000, 7'b1111001, 0);

        // Reset held with live inputs: display stays dark.
        rst = 1'b1;
        drive(vecs[1]);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_off("reset");
        end
        rst = 1'b0;
        n = 0;

        // First frame shows the cleared snapshot, then the held inputs.
        run_frame(vecs[0], 0, 16);
        run_frame(vecs[1], 0, 16);

        for (int i = 2; i < 6; i++) begin
            drive(vecs[i]);
            to_boundary();
            run_frame(vecs[i], 0, 16);
        end

        // Mid-frame input change must wait for the next frame boundary.
        drive(vecs[1]);
        to_boundary();
        run_frame(vecs[1], 0, 5);
        drive(vecs[6]);
        run_frame(vecs[1], 5, 16);
        run_frame(vecs[6], 0, 16);

        // Colon: over four frames exactly two have phase 1, 3 lit slot-2 cycles each.
        lows = 0;
        bad  = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (dp_a == 1'b0) begin
                lows++;
                if (an_a != 4'b1011) bad++;
            end
        end
        chk("colon_lows", 32'(lows), 32'd6);
        chk("colon_slot", 32'(bad), 32'd0);

        // Random inputs with a mid-run reset: at most one anode ever active.
        rr = $urandom_range(700, 300);
        for (int i = 0; i < 1000; i++) begin
            hr1  = 4'($urandom_range(15, 0));
            hr2  = 4'($urandom_range(15, 0));
            min1 = 4'($urandom_range(15, 0));
            min2 = 4'($urandom_range(15, 0));
            rst  = (i == rr || i == rr + 1);
            step();
            chk("onehot0", 32'($countones(~an_a) <= 1), 32'd1);
            chk("onehot0_nb", 32'($countones(~an_b) <= 1), 32'd1);
            if (rst) chk_off("rand_reset");
        end
        rst = 1'b0;

        // Reset mid-frame clears the snapshot despite live inputs.
        v = mk(5, 6, 7, 8, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010, 0);
        drive(v);
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        chk_off("mid_reset");
        rst = 1'b0;
        n = 0;
        run_frame(vecs[0], 0, 16);
        run_frame(v, 0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_display_mux.md
# clock_display_mux

Display back end for the real-time clock. Takes the four BCD time digits produced by the hour/minute counter (hours tens/units, minutes tens/units) and drives a 4-digit common-anode multiplexed 7-segment display with a blinking colon. Each frame latches a coherent snapshot of the digits, blanks a leading hour zero, and inserts a dead cycle between digits to prevent ghosting.

## Interface
- REFRESH_DIV, 50000, clock cycles per digit slot (≥2)
- BLINK_FRAMES, 250, frames per colon half-period (≥1)
- BLANK_LEAD, 1, 1 = blank hours-tens digit when 0
- div_clk  in  1  system clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- hr1_i  in  4  hours tens digit (BCD)
- hr2_i  in  4  hours units digit (BCD)
- min1_i  in  4  minutes tens digit (BCD)
- min2_i  in  4  minutes units digit (BCD)
- an_o  out  4  digit anode enables, active-low; an_o[0] = rightmost (min2)
- seg_o  out  7  segments, active-low; seg_o[0]=a … seg_o[6]=g
- dp_o  out  1  colon/decimal point, active-low, shown on slot 2

## Operation
- Prescaler pre counts 0..REFRESH_DIV-1, wraps to 0; "tick" = edge where pre==REFRESH_DIV-1.
- Scan index scan (2 bits) increments on tick, wraps 3→0. Slot map: 0=min2, 1=min1, 2=hr2, 3=hr1.
- Shadow registers: all four inputs captured together on the tick that takes scan 3→0. Inputs changing mid-frame never appear until the next frame.
- Blink: frame counter counts frames (scan 3→0 wraps) 0..BLINK_FRAMES-1; on its wrap, phase toggles.
- Output function (registered), computed from previous-cycle pre/scan/shadow/phase:
  - pre==0: dead cycle, an_o=4'b1111, seg_o=7'b1111111, dp_o=1.
  - else an_o = active-low one-hot of scan; seg_o = encode(shadow[scan]).
  - scan==3, BLANK_LEAD=1, shadow hr1==0: an_o=4'b1111, seg_o=7'b1111111.
  - dp_o=0 only when scan==2, pre≠0, phase==1; else 1.
- Encoding (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any value 10–15 = 0111111 (dash).
- No interaction with counter buttons; purely a consumer.

## Timing
- Reset (rst_i=1 at an edge): pre=0, scan=0, frame counter=0, phase=0, shadow=all 0; outputs an_o=4'b1111, seg_o=7'b1111111, dp_o=1 on that same edge.
- Reset mid-operation: same values on the next edge regardless of slot; shadow cleared (first frame after reset shows 0 0 0 with hr1 blanked when BLANK_LEAD=1).
- After release: edge 1 = dead cycle (all off); from edge 2 an_o=4'b1110 for REFRESH_DIV-1 cycles; then 1 dead cycle; then next slot.
- Slot period REFRESH_DIV cycles (1 dead + REFRESH_DIV-1 lit); frame = 4·REFRESH_DIV cycles; colon half-period = BLINK_FRAMES·4·REFRESH_DIV cycles.
- Input-to-display latency: value sampled at the frame boundary appears on its slot within ≤1 frame + 2 cycles.
- Never more than one an_o bit low in any cycle.

## Test plan
Bench parameters REFRESH_DIV=4, BLINK_FRAMES=2.
- Reset: rst_i=1 for 3 cycles with inputs 1,2,3,4 -> an_o=1111, seg_o=1111111, dp_o=1 every cycle; first frame after release shows min2/min1/hr2 = 1000000, slot 3 fully off.
- Hold hr1=1, hr2=2, min1=3, min2=4 -> from second frame, slots 0..3 show 0011001, 0110000, 0100100, 1111001 with an_o 1110,1101,1011,0111; each slot 3 lit + 1 dead cycle.
- Change min2 4→7 during slot 1 -> slot 0 keeps 0011001 until next 3→0 wrap, then 1111000.
- hr1=0: BLANK_LEAD=1 -> an_o=1111 throughout slot 3; BLANK_LEAD=0 -> an_o=0111, seg_o=1000000.
- min1=12 -> slot 1 seg_o=0111111.
- Colon: dp_o=0 only in lit slot-2 cycles of frames with phase 1; phase toggles every 32 cycles; assert one-hot-or-none on an_o across 1000 random-input cycles with a random mid-frame reset.
